// File: rtl/ctrl_seq_ws_if.sv
// ---------------------------------------------------------------------------
// ctrl_seq_ws_if: control interface between the hardwired sequencer and the
// accumulator CPU datapath/memory.
//   Datapath -> sequencer : instr, cpu_state, Z, mem_ready, step_mode, step_go
//   Sequencer -> datapath : ctl_load[10:0], ctl_bus[5:0], alus, mem_rd, mem_wr,
//                           clr, halted, fault, illegal
// master = sequencer side, slave = datapath side.
// ---------------------------------------------------------------------------
interface ctrl_seq_ws_if #(
  parameter int IW    = 8,
  parameter int ALU_W = 4
);
  logic [IW-1:0]    instr;
  logic [1:0]       cpu_state;
  logic             Z;
  logic             mem_ready;
  logic             step_mode;
  logic             step_go;
  logic [10:0]      ctl_load;
  logic [5:0]       ctl_bus;
  logic [ALU_W-1:0] alus;
  logic             mem_rd;
  logic             mem_wr;
  logic             clr;
  logic             halted;
  logic             fault;
  logic             illegal;

  modport master (
    input  instr, cpu_state, Z, mem_ready, step_mode, step_go,
    output ctl_load, ctl_bus, alus, mem_rd, mem_wr, clr, halted, fault, illegal
  );

  modport slave (
    output instr, cpu_state, Z, mem_ready, step_mode, step_go,
    input  ctl_load, ctl_bus, alus, mem_rd, mem_wr, clr, halted, fault, illegal
  );
endinterface

// File: rtl/ctrl_seq_ws.sv
// ---------------------------------------------------------------------------
// ctrl_seq_ws: hardwired control sequencer for the 8-bit accumulator CPU.
// Binary step counter T0..T7, combinational decode from IR, memory
// wait-states with a timeout watchdog, single-step pause, HALT opcode and
// illegal-opcode detection.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   cpu  - ctrl_seq_ws_if.master (decode inputs in, strobes/status out)
// Strobes are combinational (Mealy on mem_ready, Z and instr).
// ---------------------------------------------------------------------------
module ctrl_seq_ws #(
  parameter int             IW       = 8,
  parameter int             ALU_W    = 4,
  parameter int             WAIT_W   = 4,
  parameter int             WAIT_MAX = 12,
  parameter logic [1:0]     RUN_CODE = 2'b11,
  parameter logic [IW-1:0]  HALT_OP  = IW'(8'hFF)
) (
  input  logic          clk,
  input  logic          rst,
  ctrl_seq_ws_if.master cpu
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSE, S_HALT, S_FAULT} state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDAC = 4'h1, OP_STAC = 4'h2, OP_MOVAC = 4'h3,
    OP_MOVR = 4'h4, OP_JUMP = 4'h5, OP_JMPZ = 4'h6, OP_JPNZ  = 4'h7,
    OP_ADD  = 4'h8, OP_SUB  = 4'h9, OP_INAC = 4'hA, OP_CLAC  = 4'hB,
    OP_AND  = 4'hC, OP_OR   = 4'hD, OP_XOR  = 4'hE, OP_NOT   = 4'hF
  } opcode_e;

  // ctl_load bit positions
  localparam int AR_LOAD = 0, AR_INC = 1, PC_LOAD = 2, PC_INC = 3, DR_LOAD = 4,
                 IR_LOAD = 5, TR_LOAD = 6, R_LOAD = 7, AC_LOAD = 8, Z_LOAD = 9,
                 AC_LOADR = 10;
  // ctl_bus bit positions
  localparam int PC_BUS = 0, DR_BUSD = 1, DR_BUSA = 2, TR_BUS = 3, R_BUS = 4,
                 AC_BUS = 5;

  state_e            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              legal, is_halt, jmp, skip;
  opcode_e           op;
  logic [10:0]       ld;
  logic [5:0]        bs;
  logic [ALU_W-1:0]  al;
  logic              rd, wr, last;
  logic              active, stall, adv, timeout;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
    end
  end

  // Raw micro-step decode, before stall masking and run gating.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    legal   = (cpu.instr[IW-1:4] == '0);
    is_halt = (step_q == 3'd3) && (cpu.instr == HALT_OP);
    op      = legal ? opcode_e'(cpu.instr[3:0]) : OP_NOP;  // illegal runs as NOP
    jmp     = (op == OP_JUMP) || (op == OP_JMPZ && cpu.Z) || (op == OP_JPNZ && !cpu.Z);
    skip    = (op == OP_JMPZ && !cpu.Z) || (op == OP_JPNZ && cpu.Z);
    ld   = '0;
    bs   = '0;
    al   = '0;
    rd   = 1'b0;
    wr   = 1'b0;
    last = 1'b0;
    case (step_q)
      3'd0: begin bs[PC_BUS] = 1'b1; ld[AR_LOAD] = 1'b1; end
      3'd1: begin rd = 1'b1; ld[DR_LOAD] = 1'b1; ld[PC_INC] = 1'b1; end
      3'd2: begin bs[PC_BUS] = 1'b1; ld[AR_LOAD] = 1'b1; ld[IR_LOAD] = 1'b1; end
      default: begin
        if (jmp) begin
          case (step_q)
            3'd3: begin rd = 1'b1; ld[DR_LOAD] = 1'b1; ld[AR_INC] = 1'b1; end
            3'd4: begin rd = 1'b1; ld[DR_LOAD] = 1'b1; ld[TR_LOAD] = 1'b1; end
            3'd5: begin
              bs[DR_BUSA] = 1'b1; bs[TR_BUS] = 1'b1; ld[PC_LOAD] = 1'b1; last = 1'b1;
            end
            default: ;
          endcase
        end else if (skip) begin
          // Not-taken branch still steps PC over the two address bytes.
          case (step_q)
            3'd4: ld[PC_INC] = 1'b1;
            3'd5: begin ld[PC_INC] = 1'b1; last = 1'b1; end
            default: ;
          endcase
        end else begin
          case (op)
            OP_LDAC, OP_STAC: begin
              case (step_q)
                3'd3: begin
                  rd = 1'b1; ld[DR_LOAD] = 1'b1; ld[AR_INC] = 1'b1; ld[PC_INC] = 1'b1;
                end
                3'd4: begin
                  rd = 1'b1; ld[DR_LOAD] = 1'b1; ld[PC_INC] = 1'b1; ld[TR_LOAD] = 1'b1;
                end
                3'd5: begin bs[DR_BUSA] = 1'b1; bs[TR_BUS] = 1'b1; ld[AR_LOAD] = 1'b1; end
                3'd6: begin
                  ld[DR_LOAD] = 1'b1;
                  if (op == OP_LDAC) rd = 1'b1;
                  else               bs[AC_BUS] = 1'b1;
                end
                3'd7: begin
                  bs[DR_BUSD] = 1'b1;
                  last        = 1'b1;
                  if (op == OP_LDAC) ld[AC_LOADR] = 1'b1;
                  else               wr = 1'b1;
                end
                default: ;
              endcase
            end
            OP_MOVAC: begin bs[AC_BUS] = 1'b1; ld[R_LOAD] = 1'b1; last = 1'b1; end
            OP_MOVR:  begin bs[R_BUS] = 1'b1; ld[AC_LOADR] = 1'b1; last = 1'b1; end
            OP_NOP:   last = 1'b1;
            default: begin
              // Remaining opcodes are single-step ALU operations.
              ld[AC_LOAD] = 1'b1;
              ld[Z_LOAD]  = 1'b1;
              last        = 1'b1;
              case (op)
                OP_CLAC: al = ALU_W'(4'b0000);
                OP_ADD:  al = ALU_W'(4'b0001);
                OP_SUB:  al = ALU_W'(4'b0010);
                OP_INAC: al = ALU_W'(4'b0011);
                OP_AND:  al = ALU_W'(4'b0100);
                OP_OR:   al = ALU_W'(4'b0101);
                OP_NOT:  al = ALU_W'(4'b0110);
                default: al = ALU_W'(4'b0111);   // OP_XOR
              endcase
              bs[R_BUS] = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                          (op == OP_OR)  || (op == OP_XOR);
            end
          endcase
        end
      end
    endcase
    if (is_halt) last = 1'b1;
  end

  // Stall masking, outputs and next-state logic.
  always_comb begin
    active  = (state_q == S_RUN) && (cpu.cpu_state == RUN_CODE);
    stall   = active && (rd || wr) && !cpu.mem_ready;
    adv     = active && !stall;
    timeout = stall && (wait_q == WAIT_W'(WAIT_MAX));

    // Bus/address strobes are held while stalled; loads fire only on the
    // completing cycle.
    cpu.ctl_load = adv    ? ld : '0;
    cpu.ctl_bus  = active ? bs : '0;
    cpu.alus     = active ? al : '0;
    cpu.mem_rd   = active && rd;
    cpu.mem_wr   = active && wr;
    cpu.clr      = adv && last;
    cpu.illegal  = active && (step_q == 3'd3) && !legal && !is_halt;
    cpu.halted   = (state_q == S_HALT);
    cpu.fault    = (state_q == S_FAULT);

    state_d = state_q;
    step_d  = '0;
    wait_d  = '0;
    case (state_q)
      S_IDLE:  if (cpu.cpu_state == RUN_CODE) state_d = S_RUN;
      S_RUN: begin
        if (cpu.cpu_state != RUN_CODE) begin
          state_d = S_IDLE;                 // abort beats timeout
        end else if (stall) begin
          step_d = step_q;
          if (timeout) begin
            state_d = S_FAULT;
            step_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else if (last) begin
          if (is_halt)            state_d = S_HALT;
          else if (cpu.step_mode) state_d = S_PAUSE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_PAUSE: begin
        if (cpu.cpu_state != RUN_CODE) state_d = S_IDLE;
        else if (cpu.step_go)          state_d = S_RUN;
      end
      default: ;                            // HALT/FAULT leave only via rst
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq_ws.sv
// ---------------------------------------------------------------------------
// tb_ctrl_seq_ws: scoreboard bench for ctrl_seq_ws. Each driven cycle pushes
// the expected output vector; a negedge monitor pops and compares.
// Vector layout: {ctl_load, ctl_bus, alus, mem_rd, mem_wr, clr, halted,
// fault, illegal}.
// ---------------------------------------------------------------------------
module tb_ctrl_seq_ws;

  localparam logic [10:0] L0 = '0, AR_LOAD = 11'h001, AR_INC = 11'h002,
                          PC_LOAD = 11'h004, PC_INC = 11'h008, DR_LOAD = 11'h010,
                          IR_LOAD = 11'h020, TR_LOAD = 11'h040, R_LOAD = 11'h080,
                          AC_LOAD = 11'h100, Z_LOAD = 11'h200, AC_LOADR = 11'h400;
  localparam logic [5:0]  B0 = '0, PC_BUS = 6'h01, DR_BUSD = 6'h02, DR_BUSA = 6'h04,
                          TR_BUS = 6'h08, R_BUS = 6'h10, AC_BUS = 6'h20;
  localparam logic [3:0]  A0 = '0;
  localparam logic [5:0]  F0 = '0, F_RD = 6'b100000, F_WR = 6'b010000,
                          F_CLR = 6'b001000, F_HLT = 6'b000100, F_FLT = 6'b000010,
                          F_ILL = 6'b000001;

  typedef struct {
    string       tag;
    logic [26:0] vec;
  } sb_item_t;

  logic     clk = 1'b0;
  logic     rst;
  sb_item_t sb[$];
  sb_item_t item;
  int       n_vec = 0;
  int       n_err = 0;

  logic [7:0] alu_op[8]   = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
  logic [3:0] alu_code[8] = '{4'b0001, 4'b0010, 4'b0011, 4'b0000,
                              4'b0100, 4'b0101, 4'b0111, 4'b0110};
  logic       alu_rbus[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  ctrl_seq_ws_if #(.IW(8), .ALU_W(4)) cpu ();

  ctrl_seq_ws dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [26:0] v(input logic [10:0] ld, input logic [5:0] bs,
                                    input logic [3:0] al, input logic [5:0] fl);
    return {ld, bs, al, fl};
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      item = sb.pop_front();
      check(item.tag,
            {5'b0, cpu.ctl_load, cpu.ctl_bus, cpu.alus, cpu.mem_rd, cpu.mem_wr,
             cpu.clr, cpu.halted, cpu.fault, cpu.illegal},
            {5'b0, item.vec});
    end
  end

  // One clock of stimulus with its expected output.
  task automatic cyc(input string tag, input logic [26:0] e, input logic rdy = 1'b1);
    sb_item_t it;
    cpu.mem_ready = rdy;
    it.tag = tag;
    it.vec = e;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // One clock with nothing compared.
  task automatic idle_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string n);
    cyc({n, ".t0"}, v(AR_LOAD, PC_BUS, A0, F0));
    cyc({n, ".t1"}, v(DR_LOAD | PC_INC, B0, A0, F_RD));
    cyc({n, ".t2"}, v(AR_LOAD | IR_LOAD, PC_BUS, A0, F0));
  endtask

  task automatic mem_ref(input string n, input bit stac, input int waits);
    cyc({n, ".t3"}, v(DR_LOAD | AR_INC | PC_INC, B0, A0, F_RD));
    cyc({n, ".t4"}, v(DR_LOAD | PC_INC | TR_LOAD, B0, A0, F_RD));
    cyc({n, ".t5"}, v(AR_LOAD, DR_BUSA | TR_BUS, A0, F0));
    if (stac) begin
      cyc({n, ".t6"}, v(DR_LOAD, AC_BUS, A0, F0));
      cyc({n, ".t7"}, v(L0, DR_BUSD, A0, F_WR | F_CLR));
    end else begin
      for (int i = 0; i < waits; i++) cyc({n, ".t6w"}, v(L0, B0, A0, F_RD), 1'b0);
      cyc({n, ".t6"}, v(DR_LOAD, B0, A0, F_RD));
      cyc({n, ".t7"}, v(AC_LOADR, DR_BUSD, A0, F_CLR));
    end
  endtask

  task automatic jump_taken(input string n);
    cyc({n, ".t3"}, v(DR_LOAD | AR_INC, B0, A0, F_RD));
    cyc({n, ".t4"}, v(DR_LOAD | TR_LOAD, B0, A0, F_RD));
    cyc({n, ".t5"}, v(PC_LOAD, DR_BUSA | TR_BUS, A0, F_CLR));
  endtask

  task automatic jump_not(input string n);
    cyc({n, ".t3"}, v(L0, B0, A0, F0));
    cyc({n, ".t4"}, v(PC_INC, B0, A0, F0));
    cyc({n, ".t5"}, v(PC_INC, B0, A0, F_CLR));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cpu.instr = 8'h00; cpu.cpu_state = 2'b11; cpu.Z = 1'b0; cpu.mem_ready = 1'b1;
    cpu.step_mode = 1'b0; cpu.step_go = 1'b0;
    idle_cyc();
    cyc("rst.c0", '0);
    cyc("rst.c1", '0);
    rst = 1'b0;
    cyc("idle", '0);

    cpu.instr = 8'h00; fetch("nop"); cyc("nop.t3", v(L0, B0, A0, F_CLR));
    cpu.instr = 8'h01; fetch("ldac"); mem_ref("ldac", 1'b0, 0);
    cpu.instr = 8'h01; fetch("ldacw"); mem_ref("ldacw", 1'b0, 2);
    cpu.instr = 8'h02; fetch("stac"); mem_ref("stac", 1'b1, 0);
    cpu.instr = 8'h03; fetch("movac"); cyc("movac.t3", v(R_LOAD, AC_BUS, A0, F_CLR));
    cpu.instr = 8'h04; fetch("movr"); cyc("movr.t3", v(AC_LOADR, R_BUS, A0, F_CLR));
    cpu.instr = 8'h05; fetch("jump"); jump_taken("jump");
    cpu.Z = 1'b0; cpu.instr = 8'h06; fetch("jmpz0"); jump_not("jmpz0");
    cpu.Z = 1'b1; cpu.instr = 8'h06; fetch("jmpz1"); jump_taken("jmpz1");
    cpu.Z = 1'b0; cpu.instr = 8'h07; fetch("jpnz0"); jump_taken("jpnz0");
    cpu.Z = 1'b1; cpu.instr = 8'h07; fetch("jpnz1"); jump_not("jpnz1");
    cpu.Z = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cpu.instr = alu_op[i];
      fetch($sformatf("alu%0d", i));
      cyc($sformatf("alu%0d.t3", i),
          v(AC_LOAD | Z_LOAD, alu_rbus[i] ? R_BUS : B0, alu_code[i], F_CLR));
    end

    cpu.instr = 8'h23; fetch("ill"); cyc("ill.t3", v(L0, B0, A0, F_CLR | F_ILL));

    // Reset in the middle of LDAC T5.
    cpu.instr = 8'h01; fetch("rstmid");
    cyc("rstmid.t3", v(DR_LOAD | AR_INC | PC_INC, B0, A0, F_RD));
    cyc("rstmid.t4", v(DR_LOAD | PC_INC | TR_LOAD, B0, A0, F_RD));
    rst = 1'b1; idle_cyc(); rst = 1'b0;
    cyc("rstmid.after", '0);
    fetch("rstmid2"); mem_ref("rstmid2", 1'b0, 0);

    // cpu_state drop aborts the instruction.
    fetch("drop");
    cyc("drop.t3", v(DR_LOAD | AR_INC | PC_INC, B0, A0, F_RD));
    cpu.cpu_state = 2'b00; idle_cyc();
    cyc("drop.idle", '0);
    cpu.cpu_state = 2'b11;
    cyc("drop.resume", '0);
    cpu.instr = 8'h00; fetch("drop.nop"); cyc("drop.nop.t3", v(L0, B0, A0, F_CLR));

    // Single-step.
    cpu.step_mode = 1'b1; cpu.instr = 8'h08; fetch("ss");
    cyc("ss.t3", v(AC_LOAD | Z_LOAD, R_BUS, 4'b0001, F_CLR));
    cyc("ss.pause0", '0);
    cyc("ss.pause1", '0);
    cpu.step_go = 1'b1; cyc("ss.go", '0);
    cpu.step_go = 1'b0; cpu.step_mode = 1'b0; cpu.instr = 8'h00;
    fetch("ss.next"); cyc("ss.next.t3", v(L0, B0, A0, F_CLR));

    // Watchdog: mem_ready stuck low at T1.
    cyc("wd.t0", v(AR_LOAD, PC_BUS, A0, F0));
    for (int i = 0; i < 13; i++) cyc($sformatf("wd.stall%0d", i), v(L0, B0, A0, F_RD), 1'b0);
    cyc("wd.fault0", v(L0, B0, A0, F_FLT), 1'b0);
    cyc("wd.fault1", v(L0, B0, A0, F_FLT));
    cpu.cpu_state = 2'b00;
    cyc("wd.sticky", v(L0, B0, A0, F_FLT));
    rst = 1'b1; idle_cyc(); rst = 1'b0; cpu.cpu_state = 2'b11;
    cyc("wd.clear", '0);

    // HALT opcode.
    cpu.instr = 8'hFF; fetch("halt");
    cyc("halt.t3", v(L0, B0, A0, F_CLR));
    cyc("halt.h0", v(L0, B0, A0, F_HLT));
    cpu.cpu_state = 2'b00;
    cyc("halt.h1", v(L0, B0, A0, F_HLT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_seq_ws.md
Name: ctrl_seq_ws

Overview:
- Next-generation hardwired control sequencer for the 8-bit accumulator CPU.
- Runs the same 16-instruction ISA and fetch/execute micro-steps as the current controller.
- Uses a binary step counter, combinational decode from IR and a packed strobe interface.
- Adds memory wait-states with a timeout watchdog, single-step mode, a HALT opcode and illegal-opcode detection.

Parameters:
IW, 8, instruction width; opcode field is instr[3:0], instr[IW-1:4] must be 0 for a legal op
ALU_W, 4, alus width
WAIT_W, 4, wait-state counter width
WAIT_MAX, 12, wait cycles tolerated per memory step before fault (must be < 2^WAIT_W)
RUN_CODE, 2'b11, cpu_state encoding meaning RUN
HALT_OP, 8'hFF, opcode that halts the sequencer

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
instr  in  IW  IR output, stable from step 3
cpu_state  in  2  CPU mode; sequencing only when equal to RUN_CODE
Z  in  1  zero flag
mem_ready  in  1  memory completes the current mem_rd/mem_wr this cycle
step_mode  in  1  1 = pause after every instruction
step_go  in  1  single-cycle pulse releasing a pause
ctl_load  out  11  [0]ARload [1]ARinc [2]PCload [3]PCinc [4]DRload [5]IRload [6]TRload [7]Rload [8]ACload [9]Zload [10]ACloadR
ctl_bus  out  6  [0]PCbus [1]DRbusd [2]DRbusa [3]TRbus [4]Rbus [5]ACbus
alus  out  ALU_W  ALU function select
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
clr  out  1  pulse on the last step of each instruction
halted  out  1  HALT state
fault  out  1  FAULT state (sticky until rst)
illegal  out  1  one-cycle pulse at step 3 for an illegal opcode

Behaviour:
- Reset: clock and reset are as stated in the interface (clk, rst, synchronous active-high; this is fixed). rst has priority over every other input.
- Reset values: state=IDLE, step=0, wait counter=0; every output 0.
- FSM states: IDLE, RUN, PAUSE, HALT, FAULT.
  - IDLE -> RUN when cpu_state==RUN_CODE.
  - RUN, PAUSE -> IDLE when cpu_state!=RUN_CODE. The current instruction is aborted: step=0, strobes 0.
  - HALT and FAULT are left only by rst.
- Step counter: 3-bit binary, starting at T0.
  - Advances when adv=1.
  - Returns to T0 on the end step, i.e. when clr=1 and adv=1.
- Advance rule: adv = RUN & (step not a memory step | mem_ready).
  - A memory step is one asserting mem_rd or mem_wr.
  - While stalled: mem_rd/mem_wr, ctl_bus and alus are held; all ctl_load bits and clr are forced to 0.
  - Loads and increments therefore fire only on the completing cycle.
- Watchdog:
  - Wait counter increments on every stalled cycle and clears on adv.
  - When the counter reaches WAIT_MAX with mem_ready=0: go to FAULT next cycle. All strobes are 0 from then on and fault=1.
- Fetch steps:
  - T0: PCbus, ARload.
  - T1: mem_rd, DRload, PCinc.
  - T2: PCbus, ARload, IRload.
- Execute steps, decoded combinationally from instr during T3 onward:
  - NOP T3 end.
  - LDAC:
    - T3: mem_rd, DRload, ARinc, PCinc.
    - T4: mem_rd, DRload, PCinc, TRload.
    - T5: DRbusa, TRbus, ARload.
    - T6: mem_rd, DRload.
    - T7: DRbusd, ACloadR, end.
  - STAC: T3–T5 as LDAC; T6: ACbus, DRload; T7: DRbusd, mem_wr, end.
  - MOVAC: T3 ACbus, Rload, end.
  - MOVR: T3 Rbus, ACloadR, end.
  - JUMP:
    - T3: mem_rd, DRload, ARinc.
    - T4: mem_rd, DRload, TRload.
    - T5: DRbusa, TRbus, PCload, end.
  - JMPZ: taken when Z=1, with JUMP steps. Not taken: T3 no strobe; T4 PCinc; T5 PCinc, end.
  - JPNZ: same as JMPZ with the condition inverted. Z is sampled combinationally each step.
  - ALU ops at T3, asserting ACload and Zload, with Rbus added for ADD/SUB/AND/OR/XOR, then end.
  - alus codes: CLAC 0000, ADD 0001, SUB 0010, INAC 0011, AND 0100, OR 0101, NOT 0110, XOR 0111. alus is 0 in all other steps.
- HALT_OP at T3:
  - clr=1 that cycle.
  - RUN -> HALT; halted=1.
  - Takes priority over the illegal check.
- Illegal opcode (upper bits nonzero and not HALT_OP):
  - Executes as NOP.
  - illegal=1 for that T3 cycle.
- Single-step: on the end step with step_mode=1, go RUN -> PAUSE, step=0.
  - PAUSE -> RUN on step_go=1.
  - step_go in RUN is ignored.
- Simultaneous events:
  - rst beats everything.
  - cpu_state drop beats timeout.
  - A timeout on the end step gives FAULT, and clr is not asserted.

Test Plan:
1. rst held 2 cycles, cpu_state=11 -> all outputs 0, then T0 asserts ctl_bus[0] and ctl_load[0]. rst at LDAC T5 -> next cycle step=0 and outputs 0.
2. NOP, mem_ready=1 -> instruction takes 4 cycles, clr only at T3, ctl_load[3] (PCinc) once at T1. LDAC -> 8 cycles, ACloadR at T7.
3. LDAC with mem_ready=0 for 2 cycles at T6 -> 10 cycles total, mem_rd held 3 cycles, DRload only on the ready cycle.
4. JMPZ with Z=0 -> PCinc at T4 and T5, no PCload, no mem_rd after T2. With Z=1 -> PCload at T5.
5. mem_ready stuck 0 at T1 with WAIT_MAX=12 -> fault=1 after 13 cycles, strobes 0; only rst clears it.
6. step_mode=1 with ADD -> alus=0001 at T3, then PAUSE. step_go fetches the next instr. instr=8'h23 -> illegal pulse. instr=8'hFF -> halted=1.
